parity_scheduler: RTL
=====================

# parity_scheduler

Shares one CHUNK-bit parity reduction unit among N_REQ requesters and sequences each WIDTH-bit request through it chunk by chunk, accumulating a single parity bit per request. Requests are accepted round-robin over a valid/ready handshake. Each result is returned with the requester ID over a second valid/ready handshake that supports backpressure. The block sits between parity clients (bus-word checkers, test-vector generators) and the shared parity datapath.

## Interface
- N_REQ, 4: number of requesters; must be 2 or more.
- WIDTH, 32: request word width; must be a multiple of CHUNK.
- CHUNK, 8: parity unit input width; NCHUNK = WIDTH/CHUNK.
- clock  in  1  clock; all state updates on its rising edge.
- reset  in  1  reset: synchronous, active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_data  in  N_REQ*WIDTH  flattened; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  N_REQ  one-hot or zero; request i is accepted on a rising edge where req_valid[i] && req_ready[i].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_parity  out  1  parity of the accepted word.
- rsp_id  out  $clog2(N_REQ)  index of the requester that owns the result.
- busy  out  1  high in ACCUM and RESP.

## Operation
- FSM states:
  - IDLE: if any req_valid is high, grant g = first valid requester searching from last_grant+1 with wrap-around. req_ready[g] is driven combinationally high in this cycle only. On the edge: latch req_data slice g into word, set id<=g, last_grant<=g, acc<=0, idx<=0, go to ACCUM. If no request is valid, stay in IDLE with req_ready all 0.
  - ACCUM: each cycle acc <= acc ^ parity_unit(word[idx*CHUNK +: CHUNK]) and idx <= idx+1. When idx==NCHUNK-1, go to RESP. req_ready stays all 0.
  - RESP: rsp_valid=1, rsp_parity=acc, rsp_id=id. Hold until rsp_valid && rsp_ready, then go to IDLE. req_ready stays all 0.
- Only one request is in flight at a time. New grants happen only in IDLE.
- req_data is sampled once, at acceptance. Later changes on req_data have no effect on the result.
- Requesters not granted hold their requests; no request is ever dropped.
- rsp_parity and rsp_id are stable while rsp_valid=1 and rsp_ready=0.
- Width rules:
  - idx is $clog2(NCHUNK) bits, minimum 1.
  - last_grant and id are $clog2(N_REQ) bits.
  - last_grant wraps from N_REQ-1 to 0.

## Timing
- Reset (synchronous, dominates everything):
  - State: IDLE; last_grant=N_REQ-1, so requester 0 has priority first; acc=0, idx=0, id=0.
  - Outputs: rsp_valid=0, rsp_parity=0, rsp_id=0, busy=0, req_ready=0.
- Reset during ACCUM or RESP discards the transaction; no response is produced.
- Latency: accept at edge T; rsp_valid goes high after edge T+NCHUNK (4 cycles at the defaults).
- Best-case throughput is one request per NCHUNK+2 cycles: one IDLE cycle, NCHUNK ACCUM cycles, one RESP cycle.
- An rsp_ready that is already high when RESP is entered completes the response in that RESP cycle.
- If req_valid drops in the same cycle req_ready is high, no transfer occurs.

## Configuration
- PARITY_SCHEDULER_ODD_EN defined: rsp_parity = ~acc (odd parity; an all-zero word returns 1).
- PARITY_SCHEDULER_ODD_EN undefined: rsp_parity = acc (even parity, plain XOR reduction).
- Handshake timing and latency are identical in both builds.

## Structure
- Package parity_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCUM, RESP} parity_state_t;
  - default constants for N_REQ, WIDTH and CHUNK;
  - function rr_next(valid, last) returning the round-robin grant index.
- Sub-module parity_unit #(CHUNK): purely combinational, y = ^a. It is instantiated once and is the only shared resource.

## Test plan
Defaults N_REQ=4, WIDTH=32, CHUNK=8; macro undefined unless stated.
- Single request: req0 with 0x00000001, rsp_ready=1 → req_ready[0] high one cycle; rsp_valid 4 cycles after acceptance with rsp_parity=1, rsp_id=0; busy falls after the response.
- All four valid at once with 0x3, 0x7, 0xF, 0x1F → responses in order id 0,1,2,3 with parity 0,1,0,1; each requester accepted exactly once.
- Fairness: req0 and req2 held valid continuously → grant sequence 0,2,0,2,…; requesters 1 and 3 never granted.
- Backpressure: rsp_ready low for 5 cycles in RESP → rsp_valid, rsp_parity and rsp_id stable; req_ready all 0; completes on the first cycle rsp_ready=1.
- Reset during ACCUM (idx=2) → next cycle busy=0 and rsp_valid=0 with no response emitted; with req0 and req3 valid afterwards, req0 is granted first.
- With PARITY_SCHEDULER_ODD_EN: req1 with 0x00000000 → rsp_parity=1, rsp_id=1; 0x80000000 → rsp_parity=0.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types, default sizes and the round-robin grant helper for the parity scheduler.
package parity_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, RESP} parity_state_t;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 32;
  localparam int CHUNK_DEF = 8;
  localparam int MAX_REQ   = 32;

  // First valid requester after 'last', wrapping at n; 0 when nothing is valid.
  function automatic int rr_next(input logic [MAX_REQ-1:0] valid, input int last, input int n);
    int grant;
    int cand;
    grant = 0;
    // Walk from the farthest candidate back so the nearest valid one wins.
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        cand = (last + k) % n;
        if (valid[cand]) grant = cand;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/parity_unit.sv
// Combinational CHUNK-bit XOR reduction; the single datapath shared by all requesters.
module parity_unit
  import parity_pkg::*;
#(
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic [CHUNK-1:0] a,
  output logic             y
);

  assign y = ^a;

endmodule

// File: rtl/parity_scheduler.sv
// Round-robin scheduler feeding WIDTH-bit requests chunk by chunk through one shared parity unit.
// Define PARITY_SCHEDULER_ODD_EN to return odd parity instead of the plain XOR reduction.
module parity_scheduler
  import parity_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_parity,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic                     busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int ID_W   = $clog2(N_REQ);

  parity_state_t state_reg, state_next;
  logic [WIDTH-1:0] word_reg, word_next;
  logic [ID_W-1:0]  id_reg, id_next;
  logic [ID_W-1:0]  last_grant_reg, last_grant_next;
  logic             acc_reg, acc_next;
  logic [IDX_W-1:0] idx_reg, idx_next;

  logic [MAX_REQ-1:0] valid_ext;
  logic               any_valid;
  logic [ID_W-1:0]    grant_idx;
  logic [WIDTH-1:0]   req_words [N_REQ];
  logic [CHUNK-1:0]   chunks [NCHUNK];
  logic [CHUNK-1:0]   chunk_sel;
  logic               chunk_par;

  always_comb begin
    valid_ext = '0;
    valid_ext[N_REQ-1:0] = req_valid;
  end

  assign any_valid = |req_valid;
  assign grant_idx = ID_W'(rr_next(valid_ext, int'(last_grant_reg), N_REQ));

  // Grant is offered only while idle, so req_ready is one-hot or zero.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign req_words[gi] = req_data[gi*WIDTH +: WIDTH];
    assign req_ready[gi] = (state_reg == IDLE) && any_valid && (grant_idx == ID_W'(gi));
  end

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    assign chunks[gi] = word_reg[gi*CHUNK +: CHUNK];
  end

  assign chunk_sel = chunks[idx_reg];

  parity_unit #(.CHUNK(CHUNK)) u_parity (
    .a (chunk_sel),
    .y (chunk_par)
  );

  always_comb begin
    state_next      = state_reg;
    word_next       = word_reg;
    id_next         = id_reg;
    last_grant_next = last_grant_reg;
    acc_next        = acc_reg;
    idx_next        = idx_reg;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          word_next       = req_words[grant_idx];
          id_next         = grant_idx;
          last_grant_next = grant_idx;
          acc_next        = 1'b0;
          idx_next        = '0;
          state_next      = ACCUM;
        end
      end
      ACCUM: begin
        acc_next = acc_reg ^ chunk_par;
        if (idx_reg == IDX_W'(NCHUNK - 1)) begin
          idx_next   = '0;
          state_next = RESP;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      word_reg       <= '0;
      id_reg         <= '0;
      last_grant_reg <= ID_W'(N_REQ - 1);
      acc_reg        <= 1'b0;
      idx_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      word_reg       <= word_next;
      id_reg         <= id_next;
      last_grant_reg <= last_grant_next;
      acc_reg        <= acc_next;
      idx_reg        <= idx_next;
    end
  end

  assign rsp_valid = (state_reg == RESP);
  assign rsp_id    = id_reg;
  assign busy      = (state_reg != IDLE);

  // Gated by rsp_valid so the idle value is 0 in both parity senses.
`ifdef PARITY_SCHEDULER_ODD_EN
  assign rsp_parity = rsp_valid & ~acc_reg;
`else
  assign rsp_parity = rsp_valid & acc_reg;
`endif

endmodule
